cargador_resta: RTL and testbench

- Operand-loading and result-capture sequencer that sits directly upstream and downstream of the 4-bit signed subtractor on the lab board.
- Loads A, then B, from the 4 slide switches on successive presses of a load button.
- Drives A/B into the subtractor, latches its D and flags into output registers, and exposes the current state for LEDs.
- Buttons are asynchronous board inputs; they are synchronised and edge-detected here.

---
 rtl/cargador_resta.sv | 181 ++++++++++++++++++
 tb/tb_cargador_resta.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cargador_resta.sv
// ---------------------------------------------------------------------------
// cargador_resta
//
// Operand-loading and result-capture sequencer for the 4-bit signed
// subtractor on the lab board.
//
// Two presses of the load button capture operand A, then operand B, from
// the slide switches. One cycle after B is captured, the subtractor's
// difference and flags are latched into the result registers. The current
// state is also exported so it can be shown on the LEDs.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous reset, active low
//   sw        in   [W] switch value, the operand source
//   btn_load  in   raw load/advance button (asynchronous, active high)
//   btn_clr   in   raw clear button (asynchronous, active high)
//   d_in      in   [W] difference from the subtractor
//   ov_in     in   subtractor overflow flag
//   neg_in    in   subtractor negative flag
//   zero_in   in   subtractor zero flag
//   op_a      out  [W] registered operand A for the subtractor
//   op_b      out  [W] registered operand B for the subtractor
//   res       out  [W] latched difference
//   res_ov    out  latched overflow flag
//   res_neg   out  latched negative flag
//   res_zero  out  latched zero flag
//   res_valid out  high while res/flags belong to the current op_a/op_b
//   estado    out  [2] current state encoding (ESP_A=0, ESP_B=1,
//                  CALC=2, MOSTRAR=3)
// ---------------------------------------------------------------------------
module cargador_resta #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         btn_load,
    input  logic         btn_clr,
    input  logic [W-1:0] d_in,
    input  logic         ov_in,
    input  logic         neg_in,
    input  logic         zero_in,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] res,
    output logic         res_ov,
    output logic         res_neg,
    output logic         res_zero,
    output logic         res_valid,
    output logic [1:0]   estado
);

    typedef enum logic [1:0] {
        ESP_A   = 2'd0,
        ESP_B   = 2'd1,
        CALC    = 2'd2,
        MOSTRAR = 2'd3
    } estado_t;

    estado_t state_q, state_d;

    logic ld_s0, ld_s1, ld_s2;
    logic cl_s0, cl_s1, cl_s2;
    logic ld_pulse, cl_pulse;

    logic [W-1:0] op_a_d, op_b_d, res_d;
    logic         res_ov_d, res_neg_d, res_zero_d, res_valid_d;

    // Button conditioning. s0/s1 form the synchroniser and s2 remembers
    // the previous synchronised level. A held button therefore yields a
    // single one-cycle pulse. Bounce is deliberately not filtered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_s0 <= 1'b0;
            ld_s1 <= 1'b0;
            ld_s2 <= 1'b0;
            cl_s0 <= 1'b0;
            cl_s1 <= 1'b0;
            cl_s2 <= 1'b0;
        end else begin
            ld_s0 <= btn_load;
            ld_s1 <= ld_s0;
            ld_s2 <= ld_s1;
            cl_s0 <= btn_clr;
            cl_s1 <= cl_s0;
            cl_s2 <= cl_s1;
        end
    end

    assign ld_pulse = ld_s1 & ~ld_s2;
    assign cl_pulse = cl_s1 & ~cl_s2;

    // State and data registers. All next values come from the
    // combinational process below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ESP_A;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            res_ov    <= 1'b0;
            res_neg   <= 1'b0;
            res_zero  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a      <= op_a_d;
            op_b      <= op_b_d;
            res       <= res_d;
            res_ov    <= res_ov_d;
            res_neg   <= res_neg_d;
            res_zero  <= res_zero_d;
            res_valid <= res_valid_d;
        end
    end

    // Next-state and next-data logic. By default every register holds its
    // value. A clear pulse takes priority over any load pulse in the same
    // cycle.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a;
        op_b_d      = op_b;
        res_d       = res;
        res_ov_d    = res_ov;
        res_neg_d   = res_neg;
        res_zero_d  = res_zero;
        res_valid_d = res_valid;

        if (cl_pulse) begin
            state_d     = ESP_A;
            op_a_d      = '0;
            op_b_d      = '0;
            res_d       = '0;
            res_ov_d    = 1'b0;
            res_neg_d   = 1'b0;
            res_zero_d  = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ESP_A: begin
                    if (ld_pulse) begin
                        op_a_d  = sw;
                        state_d = ESP_B;
                    end
                end
                ESP_B: begin
                    if (ld_pulse) begin
                        op_b_d  = sw;
                        state_d = CALC;
                    end
                end
                // The subtractor has had a full cycle to settle on the new
                // op_b, so its outputs can be captured now. Load pulses
                // that arrive here are dropped.
                CALC: begin
                    res_d       = d_in;
                    res_ov_d    = ov_in;
                    res_neg_d   = neg_in;
                    res_zero_d  = zero_in;
                    res_valid_d = 1'b1;
                    state_d     = MOSTRAR;
                end
                // A new press starts the next operation directly. The old
                // result stays visible but is marked stale.
                MOSTRAR: begin
                    if (ld_pulse) begin
                        op_a_d      = sw;
                        res_valid_d = 1'b0;
                        state_d     = ESP_B;
                    end
                end
                default: state_d = ESP_A;
            endcase
        end
    end

    assign estado = state_q;

endmodule

// File: tb/tb_cargador_resta.sv
// ---------------------------------------------------------------------------
// tb_cargador_resta
//
// Directed testbench for cargador_resta. A small behavioural model of the
// board subtractor feeds d_in and the flags from op_a/op_b. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cargador_resta;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         btn_load;
    logic         btn_clr;
    logic [W-1:0] d_in;
    logic         ov_in;
    logic         neg_in;
    logic         zero_in;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] res;
    logic         res_ov;
    logic         res_neg;
    logic         res_zero;
    logic         res_valid;
    logic [1:0]   estado;

    int errors = 0;
    int checks = 0;

    cargador_resta #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clr   (btn_clr),
        .d_in      (d_in),
        .ov_in     (ov_in),
        .neg_in    (neg_in),
        .zero_in   (zero_in),
        .op_a      (op_a),
        .op_b      (op_b),
        .res       (res),
        .res_ov    (res_ov),
        .res_neg   (res_neg),
        .res_zero  (res_zero),
        .res_valid (res_valid),
        .estado    (estado)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational model of the board subtractor: D = A - B mod 16 in two's
    // complement. It sets the overflow flag when the operand signs differ
    // and the result sign differs from A.
    always_comb begin
        d_in    = op_a - op_b;
        ov_in   = (op_a[W-1] != op_b[W-1]) && (d_in[W-1] != op_a[W-1]);
        neg_in  = d_in[W-1];
        zero_in = (d_in == '0);
    end

    // Advance n rising edges and then step 1 unit past the last edge.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a button high across exactly one rising edge (edge k) and
    // release it afterwards.
    task automatic applyStimulus(input logic [W-1:0] val, input logic ld, input logic cl);
        sw       = val;
        btn_load = ld;
        btn_clr  = cl;
        @(posedge clk);
        #1;
        btn_load = 1'b0;
        btn_clr  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] e_st, input logic [3:0] e_a,
                            input logic [3:0] e_b, input logic [3:0] e_res, input logic e_ov,
                            input logic e_neg, input logic e_zero, input logic e_val);
        checkOutput({tag, ".estado"}, 4'(estado), 4'(e_st));
        checkOutput({tag, ".op_a"}, op_a, e_a);
        checkOutput({tag, ".op_b"}, op_b, e_b);
        checkOutput({tag, ".res"}, res, e_res);
        checkOutput({tag, ".res_ov"}, 4'(res_ov), 4'(e_ov));
        checkOutput({tag, ".res_neg"}, 4'(res_neg), 4'(e_neg));
        checkOutput({tag, ".res_zero"}, 4'(res_zero), 4'(e_zero));
        checkOutput({tag, ".res_valid"}, 4'(res_valid), 4'(e_val));
    endtask

    // Directed sequence. Each press is sampled at edge k. The action is
    // visible after edge k+2, and the result after edge k+3 for a B press.
    initial begin
        rst_n    = 1'b0;
        sw       = '0;
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        waitEdges(3);
        checkAll("reset", 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        waitEdges(2);

        // 5 - 3 = 2
        $display("[TB] basic 5-3");
        applyStimulus(4'd5, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("a_lat_k1.estado", 4'(estado), 4'd0);
        checkOutput("a_lat_k1.op_a", op_a, 4'd0);
        waitEdges(1);
        checkOutput("a_k2.estado", 4'(estado), 4'd1);
        checkOutput("a_k2.op_a", op_a, 4'd5);
        sw = 4'd9;
        waitEdges(3);
        checkOutput("a_sw_ignored.op_a", op_a, 4'd5);
        applyStimulus(4'd3, 1'b1, 1'b0);
        waitEdges(2);
        checkAll("b_k2", 2'd2, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        waitEdges(1);
        checkAll("res_5m3", 2'd3, 4'd5, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // From MOSTRAR: 7 - (-1) = 8 overflows to -8.
        $display("[TB] overflow 7-(-1)");
        applyStimulus(4'b0111, 1'b1, 1'b0);
        waitEdges(2);
        checkAll("most_a7", 2'd1, 4'd7, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        waitEdges(3);
        checkAll("res_7m15", 2'd3, 4'd7, 4'hF, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Clear from MOSTRAR, then 3 - 3 = 0.
        $display("[TB] clear then 3-3");
        applyStimulus(4'd0, 1'b0, 1'b1);
        waitEdges(2);
        checkAll("clr_most", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd3, 1'b1, 1'b0);
        waitEdges(2);
        applyStimulus(4'd3, 1'b1, 1'b0);
        waitEdges(3);
        checkAll("res_3m3", 2'd3, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // A held load button gives exactly one advance.
        $display("[TB] held load button");
        applyStimulus(4'd0, 1'b0, 1'b1);
        waitEdges(2);
        sw       = 4'd6;
        btn_load = 1'b1;
        waitEdges(4);
        sw = 4'd10;
        waitEdges(16);
        checkOutput("hold.estado", 4'(estado), 4'd1);
        checkOutput("hold.op_a", op_a, 4'd6);
        checkOutput("hold.op_b", op_b, 4'd0);
        btn_load = 1'b0;
        waitEdges(4);
        checkOutput("hold_rel.estado", 4'(estado), 4'd1);

        // In ESP_B, clear and load land in the same cycle: clear wins.
        $display("[TB] clear and load together");
        applyStimulus(4'd4, 1'b1, 1'b1);
        waitEdges(2);
        checkAll("clr_ld", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        waitEdges(3);
        checkOutput("clr_ld_later.estado", 4'(estado), 4'd0);

        // 2 - 1 = 1. Reload from MOSTRAR, then reset.
        $display("[TB] reload from MOSTRAR and reset");
        applyStimulus(4'd2, 1'b1, 1'b0);
        waitEdges(2);
        applyStimulus(4'd1, 1'b1, 1'b0);
        waitEdges(3);
        checkAll("res_2m1", 2'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd9, 1'b1, 1'b0);
        waitEdges(2);
        checkAll("most_a9", 2'd1, 4'd9, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        waitEdges(1);
        rst_n = 1'b1;
        checkAll("mid_reset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
